hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core; it is the stall/flush counterpart to the EX-stage forwarding logic.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Flushes younger stages on a taken branch and freezes the whole pipeline while data memory is busy.
- Holds a pending-flush flag across memory waits and keeps saturating stall/flush event counters for performance debug.

Parameters:
CNT_W, 16, width of o_stall_count and o_flush_count (saturating)

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst  input  1  reset, asynchronous, active-high
i_if_id_opcode  input  7  opcode of the instruction in IF/ID
i_if_id_rs1  input  5  rs1 field in IF/ID
i_if_id_rs2  input  5  rs2 field in IF/ID
i_id_ex_mem_read  input  1  ID/EX instruction is a load
i_id_ex_rd  input  5  ID/EX destination register
i_branch_taken  input  1  single-cycle pulse: branch in EX/MEM resolved taken
i_dmem_busy  input  1  data memory not ready; the pipeline must hold
i_count_clr  input  1  synchronous clear of both counters
o_pc_write  output  1  PC may update
o_if_id_write  output  1  IF/ID may load
o_id_ex_bubble  output  1  zero ID/EX control signals this cycle
o_flush_if_id  output  1  clear IF/ID
o_flush_id_ex  output  1  clear ID/EX
o_flush_ex_mem  output  1  clear EX/MEM controls
o_freeze  output  1  all pipeline registers hold
o_stall_count  output  CNT_W  saturating count of bubble and freeze cycles
o_flush_count  output  CNT_W  saturating count of flush events

Behaviour:
- Reset: i_rst is asynchronous and active-high. While it is high:
  - state = RUN, pending_flush = 0, both counters = 0;
  - outputs: o_pc_write = 0, o_if_id_write = 0, o_freeze = 1, all flush outputs = 0, o_id_ex_bubble = 0.
- Source-use decode from i_if_id_opcode:
  - uses_rs1 for 0110011 (R), 0010011 (I-ALU), 0000011 (ld), 0100011 (sd), 1100011 (beq);
  - uses_rs2 for 0110011, 0100011, 1100011;
  - all other opcodes use neither.
- load_use = i_id_ex_mem_read AND i_id_ex_rd != 0 AND ((uses_rs1 AND rd == rs1) OR (uses_rs2 AND rd == rs2)).
- Outputs are combinational from state, pending_flush and inputs (zero-cycle latency). State, pending_flush and counters are registered.
- Default outputs: o_pc_write = 1, o_if_id_write = 1, all others 0.
- State RUN, priority busy > flush > load-use:
  - i_dmem_busy = 1:
    - outputs: o_freeze = 1, o_pc_write = 0, o_if_id_write = 0, no flush, no bubble;
    - next state MEM_WAIT;
    - pending_flush <= i_branch_taken.
  - Else flush_now = i_branch_taken OR pending_flush:
    - all three flush outputs = 1; o_pc_write = 1 (PC loads the target);
    - pending_flush <= 0.
  - Else load_use:
    - o_pc_write = 0, o_if_id_write = 0, o_id_ex_bubble = 1.
    - Exactly one bubble per hazard; the next cycle the load is in EX/MEM and load_use deasserts naturally.
- State MEM_WAIT:
  - i_dmem_busy = 1: freeze outputs as above; pending_flush <= pending_flush OR i_branch_taken.
  - i_dmem_busy = 0: next state RUN. The same cycle is evaluated with the RUN flush/load-use rules, with pending_flush included in flush_now.
- Counters:
  - o_stall_count += 1 on each cycle with o_freeze or o_id_ex_bubble high.
  - o_flush_count += 1 on each cycle with flushes asserted.
  - Both saturate at 2^CNT_W - 1 with no wrap.
  - i_count_clr forces both to 0 and takes priority over increment in the same cycle.
- Simultaneous taken branch and load_use: flush wins, no bubble, stall counter unchanged.
- Reset mid-MEM_WAIT: the pending flush is discarded.

Test Plan:
- ID/EX ld rd = x5; IF/ID R-type rs1 = x5 -> one cycle of o_pc_write = 0, o_if_id_write = 0, o_id_ex_bubble = 1; o_stall_count = 1; next cycle normal.
- ld rd = x0 against rs1 = x0 -> no stall. I-ALU (0010011) with rs2 field = x5 against ld rd = x5 -> no stall. sd with rs2 = x5 -> one bubble.
- i_branch_taken pulse together with load_use -> all three flushes = 1, o_id_ex_bubble = 0, o_flush_count = 1, o_stall_count unchanged.
- i_dmem_busy high 3 cycles, i_branch_taken pulse in the 2nd busy cycle -> o_freeze = 1 for 3 cycles, flushes on the cycle busy falls, o_stall_count = 3, o_flush_count = 1.
- CNT_W = 2, 5 consecutive bubble/freeze cycles -> o_stall_count holds at 3. i_count_clr asserted with an increment -> count becomes 0.
- i_rst asserted asynchronously during MEM_WAIT with pending flush -> outputs take reset values immediately; after release, no flush occurs.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush, data-memory freeze,
// and saturating stall/flush event counters for performance debug.
module hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [6:0]       i_if_id_opcode,
    input  logic [4:0]       i_if_id_rs1,
    input  logic [4:0]       i_if_id_rs2,
    input  logic             i_id_ex_mem_read,
    input  logic [4:0]       i_id_ex_rd,
    input  logic             i_branch_taken,
    input  logic             i_dmem_busy,
    input  logic             i_count_clr,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_id_ex_bubble,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_flush_ex_mem,
    output logic             o_freeze,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             pending_flush_q, pending_flush_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic uses_rs1, uses_rs2, load_use;
    logic stall_evt, flush_evt;

    // Source-register usage by opcode class
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (i_if_id_opcode)
            OP_R, OP_SD, OP_BEQ: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IALU, OP_LD: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = i_id_ex_mem_read && (i_id_ex_rd != 5'd0) &&
                      ((uses_rs1 && (i_id_ex_rd == i_if_id_rs1)) ||
                       (uses_rs2 && (i_id_ex_rd == i_if_id_rs2)));

    // Next state and combinational controls; busy > flush > load-use
    always_comb begin
        state_d         = state_q;
        pending_flush_d = pending_flush_q;
        o_pc_write      = 1'b1;
        o_if_id_write   = 1'b1;
        o_id_ex_bubble  = 1'b0;
        o_flush_if_id   = 1'b0;
        o_flush_id_ex   = 1'b0;
        o_flush_ex_mem  = 1'b0;
        o_freeze        = 1'b0;

        if (i_dmem_busy) begin
            o_freeze      = 1'b1;
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            state_d       = MEM_WAIT;
            case (state_q)
                MEM_WAIT: pending_flush_d = pending_flush_q | i_branch_taken;
                default:  pending_flush_d = i_branch_taken;
            endcase
        end else begin
            state_d = RUN;
            if (i_branch_taken || pending_flush_q) begin
                o_flush_if_id   = 1'b1;
                o_flush_id_ex   = 1'b1;
                o_flush_ex_mem  = 1'b1;
                pending_flush_d = 1'b0;
            end else if (load_use) begin
                o_pc_write     = 1'b0;
                o_if_id_write  = 1'b0;
                o_id_ex_bubble = 1'b1;
            end
        end

        stall_evt = o_freeze | o_id_ex_bubble;
        flush_evt = o_flush_if_id;

        // Reset forces a safe frozen pipeline immediately
        if (i_rst) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_bubble = 1'b0;
            o_flush_if_id  = 1'b0;
            o_flush_id_ex  = 1'b0;
            o_flush_ex_mem = 1'b0;
            o_freeze       = 1'b1;
        end
    end

    // Saturating event counters; clear wins over increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (i_count_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_evt && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_evt && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= RUN;
            pending_flush_q <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign o_stall_count = stall_cnt_q;
    assign o_flush_count = flush_cnt_q;

endmodule
